// File: rtl/i2c_target_device.sv
// i2c_target_device: oversampled I2C target with fixed 7-bit address, byte receive and byte transmit
`timescale 1ns/1ps
module i2c_target_device #(
   parameter logic [6:0] ADDRESS = 7'h42
) (
   input  logic       i_clk,
   input  logic       i_rst,
   input  logic       i_scl,
   inout  wire        io_sda,
   input  logic [7:0] i_tx_data,
   output logic       o_tx_req,
   output logic [7:0] o_rx_data,
   output logic       o_rx_valid,
   output logic       o_addr_match,
   output logic       o_busy
);
   typedef enum logic [2:0] {IDLE, ADDR, ADDR_ACK, RX_DATA, RX_ACK, TX_DATA, TX_ACK, WAIT_STOP} state_t;
   logic [2:0] scl_q, sda_q;
   state_t     state_q, state_d;
   logic [2:0] cnt_q, cnt_d;
   logic [6:0] shift_q, shift_d;
   logic       rw_q, rw_d, ack_q, ack_d, oe_q, oe_d;
   logic [7:0] rx_data_q, rx_data_d;
   logic       rx_valid_q, rx_valid_d, match_q, match_d, busy_q, busy_d, tx_req_d;
   logic       scl_rise, scl_fall, sda, start, stop;
   assign sda      = sda_q[1];
   assign scl_rise = scl_q[1] & ~scl_q[2];
   assign scl_fall = ~scl_q[1] & scl_q[2];
   assign start    = scl_q[1] & sda_q[2] & ~sda_q[1];
   assign stop     = scl_q[1] & ~sda_q[2] & sda_q[1];
   assign io_sda       = oe_q ? 1'b0 : 1'bz;
   assign o_tx_req     = tx_req_d;
   assign o_rx_data    = rx_data_q;
   assign o_rx_valid   = rx_valid_q;
   assign o_addr_match = match_q;
   assign o_busy       = busy_q;
   // two-stage synchronisers plus one history stage; reset to the idle-bus level so no edge fires on release
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         scl_q <= 3'b111;
         sda_q <= 3'b111;
      end else begin
         scl_q <= {scl_q[1:0], i_scl};
         sda_q <= {sda_q[1:0], io_sda};
      end
   end
   // protocol state and datapath registers; async reset releases SDA at once
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q    <= IDLE;
         cnt_q      <= 3'd7;
         shift_q    <= '0;
         rw_q       <= 1'b0;
         ack_q      <= 1'b0;
         oe_q       <= 1'b0;
         rx_data_q  <= '0;
         rx_valid_q <= 1'b0;
         match_q    <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         ack_q      <= ack_d;
         oe_q       <= oe_d;
         rx_data_q  <= rx_data_d;
         rx_valid_q <= rx_valid_d;
         match_q    <= match_d;
         busy_q     <= busy_d;
      end
   end
   // next-state logic: STOP/START override everything, else SDA is sampled on SCL rise and driven on SCL fall
   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      ack_d      = ack_q;
      oe_d       = oe_q;
      rx_data_d  = rx_data_q;
      rx_valid_d = 1'b0;
      match_d    = match_q;
      busy_d     = busy_q;
      tx_req_d   = 1'b0;
      if (stop) begin
         state_d = IDLE;
         oe_d    = 1'b0;
         ack_d   = 1'b0;
         match_d = 1'b0;
         busy_d  = 1'b0;
      end else if (start) begin
         state_d = ADDR;
         cnt_d   = 3'd7;
         oe_d    = 1'b0;
         ack_d   = 1'b0;
         match_d = 1'b0;
         busy_d  = 1'b1;
      end else begin
         case (state_q)
            ADDR: if (scl_rise) begin
               shift_d = {shift_q[5:0], sda};
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  rw_d    = sda;
                  state_d = (shift_q == ADDRESS) ? ADDR_ACK : WAIT_STOP;
               end
            end
            ADDR_ACK: if (scl_fall) begin
               ack_d = ~ack_q;
               if (!ack_q) begin
                  oe_d    = 1'b1;
                  match_d = 1'b1;
               end else if (rw_q) begin
                  tx_req_d = 1'b1;
                  shift_d  = i_tx_data[6:0];
                  oe_d     = ~i_tx_data[7];
                  cnt_d    = 3'd7;
                  state_d  = TX_DATA;
               end else begin
                  oe_d    = 1'b0;
                  cnt_d   = 3'd7;
                  state_d = RX_DATA;
               end
            end
            RX_DATA: if (scl_rise) begin
               shift_d = {shift_q[5:0], sda};
               cnt_d   = cnt_q - 3'd1;
               if (cnt_q == 3'd0) begin
                  rx_data_d  = {shift_q, sda};
                  rx_valid_d = 1'b1;
                  state_d    = RX_ACK;
               end
            end
            RX_ACK: if (scl_fall) begin
               oe_d  = ~ack_q;
               ack_d = ~ack_q;
               if (ack_q) begin
                  cnt_d   = 3'd7;
                  state_d = RX_DATA;
               end
            end
            TX_DATA: if (scl_fall) begin
               if (cnt_q == 3'd0) begin
                  oe_d    = 1'b0;
                  ack_d   = 1'b0;
                  state_d = TX_ACK;
               end else begin
                  cnt_d   = cnt_q - 3'd1;
                  oe_d    = ~shift_q[6];
                  shift_d = {shift_q[5:0], 1'b0};
               end
            end
            TX_ACK: begin
               if (scl_rise) begin
                  ack_d   = ~sda;
                  state_d = sda ? WAIT_STOP : TX_ACK;
               end else if (scl_fall && ack_q) begin
                  ack_d    = 1'b0;
                  tx_req_d = 1'b1;
                  shift_d  = i_tx_data[6:0];
                  oe_d     = ~i_tx_data[7];
                  cnt_d    = 3'd7;
                  state_d  = TX_DATA;
               end
            end
            WAIT_STOP: oe_d = 1'b0;
            default: state_d = state_q;
         endcase
      end
   end
endmodule
